// File: rtl/ps2_key_events_if.sv
// ps2_key_events_if: decoded key-event FIFO pop port (master = receiver, slave = consumer)
interface ps2_key_events_if #(parameter int FIFO_DEPTH = 8);
    logic rd_en;
    logic ev_valid;
    logic [7:0] ev_code;
    logic ev_ext;
    logic ev_break;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    modport master(input rd_en, output ev_valid, ev_code, ev_ext, ev_break, fifo_count);
    modport slave(output rd_en, input ev_valid, ev_code, ev_ext, ev_break, fifo_count);
endinterface

// File: rtl/ps2_key_events.sv
// ps2_key_events: PS/2 keyboard receiver with E0/F0 decoding, typematic suppression and event FIFO
module ps2_key_events #(
    parameter int FIFO_DEPTH  = 8,
    parameter int CNT_W       = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic             CLOCK,
    input  logic             SW,
    input  logic             PS2_CLK,
    input  logic             PS2_DAT,
    ps2_key_events_if.master ev,
    output logic             overflow,
    output logic             frame_err,
    output logic [CNT_W-1:0] key_count,
    output logic [7:0]       cur_key
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

    logic [2:0]    clk_sync;
    logic [1:0]    dat_sync;
    logic          fall, dat_bit;
    logic [3:0]    bit_cnt;
    logic [9:0]    sr;
    logic [10:0]   frame;
    logic          frame_ok;
    logic [TW-1:0] tcnt;
    logic          byte_rdy, byte_err;
    logic [7:0]    rx_byte;
    state_t        state;
    logic          emit_v;
    logic [9:0]    emit_ev;
    logic [9:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wp, rp;
    logic [CW-1:0] cnt;
    logic          held_v, held_ext;
    logic [7:0]    held_code;
    logic          full, do_rd, do_wr, is_held;

    // frame[0] is the start bit once the stop bit has been shifted in
    assign frame    = {dat_bit, sr};
    assign frame_ok = !frame[0] && ^frame[9:1] && frame[10];

    always_ff @(posedge CLOCK) begin
        if (!SW) begin
            clk_sync  <= '1;
            dat_sync  <= '1;
            fall      <= 1'b0;
            dat_bit   <= 1'b1;
            bit_cnt   <= '0;
            sr        <= '0;
            tcnt      <= '0;
            byte_rdy  <= 1'b0;
            byte_err  <= 1'b0;
            rx_byte   <= '0;
            frame_err <= 1'b0;
        end else begin
            clk_sync <= {clk_sync[1:0], PS2_CLK};
            dat_sync <= {dat_sync[0], PS2_DAT};
            fall     <= clk_sync[2] & ~clk_sync[1];
            dat_bit  <= dat_sync[1];
            byte_rdy <= 1'b0;
            byte_err <= 1'b0;
            if (fall) begin
                sr      <= frame[10:1];
                tcnt    <= '0;
                bit_cnt <= (bit_cnt == 4'd10) ? 4'd0 : bit_cnt + 4'd1;
                if (bit_cnt == 4'd10) begin
                    byte_rdy  <= frame_ok;
                    byte_err  <= !frame_ok;
                    rx_byte   <= frame[8:1];
                    frame_err <= frame_err | !frame_ok;
                end
            end else if (bit_cnt == 4'd0) begin
                tcnt <= '0;
            end else if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
                bit_cnt <= '0;
                tcnt    <= '0;
            end else begin
                tcnt <= tcnt + 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK) begin
        if (!SW) begin
            state   <= IDLE;
            emit_v  <= 1'b0;
            emit_ev <= '0;
        end else begin
            emit_v <= 1'b0;
            if (byte_err) begin
                state <= IDLE;
            end else if (byte_rdy) begin
                if (rx_byte == 8'hE0)
                    state <= (state == BRK || state == EXT_BRK) ? IDLE : EXT;
                else if (rx_byte == 8'hF0)
                    state <= (state == IDLE) ? BRK : (state == EXT) ? EXT_BRK : IDLE;
                else begin
                    emit_v  <= 1'b1;
                    emit_ev <= {state == EXT || state == EXT_BRK, state == BRK || state == EXT_BRK, rx_byte};
                    state   <= IDLE;
                end
            end
        end
    end

    // a full FIFO still accepts a write when the head is popped in the same cycle
    assign full    = cnt == CW'(FIFO_DEPTH);
    assign do_rd   = ev.rd_en && cnt != '0;
    assign do_wr   = emit_v && (!full || do_rd);
    assign is_held = held_v && held_ext == emit_ev[9] && held_code == emit_ev[7:0];

    always_ff @(posedge CLOCK) begin
        if (do_wr)
            mem[wp] <= emit_ev;
    end

    always_ff @(posedge CLOCK) begin
        if (!SW) begin
            wp        <= '0;
            rp        <= '0;
            cnt       <= '0;
            overflow  <= 1'b0;
            held_v    <= 1'b0;
            held_ext  <= 1'b0;
            held_code <= '0;
            key_count <= '0;
        end else begin
            if (do_wr)
                wp <= wp + 1'b1;
            if (do_rd)
                rp <= rp + 1'b1;
            cnt <= cnt + CW'(do_wr) - CW'(do_rd);
            if (emit_v && full && !do_rd)
                overflow <= 1'b1;
            if (emit_v && !emit_ev[8] && !is_held) begin
                key_count <= key_count + 1'b1;
                held_v    <= 1'b1;
                held_ext  <= emit_ev[9];
                held_code <= emit_ev[7:0];
            end else if (emit_v && emit_ev[8] && is_held) begin
                held_v <= 1'b0;
            end
        end
    end

    assign ev.ev_valid   = cnt != '0;
    assign {ev.ev_ext, ev.ev_break, ev.ev_code} = ev.ev_valid ? mem[rp] : 10'd0;
    assign ev.fifo_count = cnt;
    assign cur_key       = held_v ? held_code : 8'h00;
endmodule

// File: tb/tb_ps2_key_events.sv
// tb_ps2_key_events: vector table, corner sequences and random frames against a scan-code event model
module tb_ps2_key_events;
    logic CLOCK = 1'b0, SW = 1'b0, PS2_CLK = 1'b1, PS2_DAT = 1'b1;
    logic overflow, frame_err, ovf2, ferr2;
    logic [7:0] key_count, cur_key, cur2;
    logic [1:0] kc2;
    int n_chk = 0, n_err = 0;

    always #5 CLOCK = ~CLOCK;

    ps2_key_events_if #(.FIFO_DEPTH(4)) ev();
    ps2_key_events_if #(.FIFO_DEPTH(4)) ev2();
    assign ev2.rd_en = 1'b0;

    ps2_key_events #(.FIFO_DEPTH(4), .CNT_W(8), .TIMEOUT_CYC(100)) dut (
        .CLOCK(CLOCK), .SW(SW), .PS2_CLK(PS2_CLK), .PS2_DAT(PS2_DAT), .ev(ev),
        .overflow(overflow), .frame_err(frame_err), .key_count(key_count), .cur_key(cur_key));

    // narrow counter instance shares the pins to observe wrap-around
    ps2_key_events #(.FIFO_DEPTH(4), .CNT_W(2), .TIMEOUT_CYC(100)) dut2 (
        .CLOCK(CLOCK), .SW(SW), .PS2_CLK(PS2_CLK), .PS2_DAT(PS2_DAT), .ev(ev2),
        .overflow(ovf2), .frame_err(ferr2), .key_count(kc2), .cur_key(cur2));

    bit m_ext, m_brk, m_ovf, m_ferr, m_hv, m_hext;
    logic [7:0] m_hcode;
    int m_cnt;
    logic [9:0] q[$];

    typedef struct {
        logic [7:0] code;
        bit         bad;
        logic [7:0] cur;
        int         cnt;
        bit         ferr;
    } vec_t;
    vec_t tbl[21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLOCK);
        #1;
    endtask

    task automatic model_reset();
        {m_ext, m_brk, m_ovf, m_ferr, m_hv, m_hext} = '0;
        m_hcode = 8'h00;
        m_cnt = 0;
        q.delete();
    endtask

    task automatic model_emit(input bit e, input bit b, input logic [7:0] c);
        if (q.size() < 4) q.push_back({e, b, c});
        else m_ovf = 1'b1;
        if (!b && !(m_hv && m_hext == e && m_hcode == c)) begin
            m_cnt++;
            m_hv = 1'b1;
            m_hext = e;
            m_hcode = c;
        end else if (b && m_hv && m_hext == e && m_hcode == c) begin
            m_hv = 1'b0;
        end
    endtask

    // a prefix after F0 abandons the sequence; otherwise prefixes accumulate
    task automatic model_byte(input logic [7:0] c, input bit bad);
        if (bad) begin
            m_ferr = 1'b1;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end else if (c == 8'hE0 || c == 8'hF0) begin
            if (m_brk) begin
                m_ext = 1'b0;
                m_brk = 1'b0;
            end else if (c == 8'hE0) m_ext = 1'b1;
            else m_brk = 1'b1;
        end else begin
            model_emit(m_ext, m_brk, c);
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic send_bits(input logic [10:0] f, input int n, input bit rd_pulse);
        for (int i = 0; i < n; i++) begin
            PS2_DAT = f[i];
            tick(4);
            PS2_CLK = 1'b0;
            for (int k = 1; k <= 8; k++) begin
                @(posedge CLOCK);
                #1;
                if (rd_pulse && i == 10 && k == 5) ev.rd_en = 1'b1;
                if (rd_pulse && i == 10 && k == 6) ev.rd_en = 1'b0;
            end
            PS2_CLK = 1'b1;
            tick(4);
        end
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] c, input bit bad);
        return {1'b1, (~^c) ^ bad, c, 1'b0};
    endfunction

    task automatic frame_m(input logic [7:0] c, input bit bad);
        send_bits(mk_frame(c, bad), 11, 1'b0);
        tick(6);
        model_byte(c, bad);
    endtask

    task automatic check_all();
        chk("fifo_count", 32'(ev.fifo_count), q.size());
        chk("ev_valid", 32'(ev.ev_valid), 32'(q.size() != 0));
        if (q.size() != 0) chk("ev_head", {ev.ev_ext, ev.ev_break, ev.ev_code}, q[0]);
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("frame_err", 32'(frame_err), 32'(m_ferr));
        chk("key_count", 32'(key_count), m_cnt % 256);
        chk("key_count_w2", 32'(kc2), m_cnt % 4);
        chk("cur_key", 32'(cur_key), m_hv ? 32'(m_hcode) : 32'h0);
    endtask

    task automatic pop_chk();
        if (q.size() != 0) chk("pop_head", {ev.ev_ext, ev.ev_break, ev.ev_code}, q[0]);
        ev.rd_en = 1'b1;
        tick(1);
        ev.rd_en = 1'b0;
        if (q.size() != 0) void'(q.pop_front());
    endtask

    task automatic drain();
        for (int i = 0; i < 8 && q.size() != 0; i++) pop_chk();
        check_all();
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] pool[10];
        logic [7:0] c;
        ev.rd_en = 1'b0;
        model_reset();
        tbl = '{
            '{8'h1C, 0, 8'h1C, 1, 0}, '{8'hF0, 0, 8'h1C, 1, 0}, '{8'h1C, 0, 8'h00, 1, 0},
            '{8'hE0, 0, 8'h00, 1, 0}, '{8'h75, 0, 8'h75, 2, 0}, '{8'hE0, 0, 8'h75, 2, 0},
            '{8'hF0, 0, 8'h75, 2, 0}, '{8'h75, 0, 8'h00, 2, 0}, '{8'h1C, 0, 8'h1C, 3, 0},
            '{8'h1C, 0, 8'h1C, 3, 0}, '{8'h1C, 0, 8'h1C, 3, 0}, '{8'h1C, 0, 8'h1C, 3, 0},
            '{8'h1C, 0, 8'h1C, 3, 0}, '{8'hF0, 0, 8'h1C, 3, 0}, '{8'h1C, 0, 8'h00, 3, 0},
            '{8'h1C, 0, 8'h1C, 4, 0}, '{8'h1C, 1, 8'h1C, 4, 1}, '{8'h32, 0, 8'h32, 5, 1},
            '{8'hF0, 0, 8'h32, 5, 1}, '{8'h1C, 1, 8'h32, 5, 1}, '{8'h1C, 0, 8'h1C, 6, 1}};
        pool = '{8'h1C, 8'h32, 8'h75, 8'h21, 8'hE0, 8'hE0, 8'hF0, 8'hF0, 8'h23, 8'h00};

        tick(3);
        chk("rst_ev_valid", 32'(ev.ev_valid), 0);
        chk("rst_fifo_count", 32'(ev.fifo_count), 0);
        chk("rst_ev_code", 32'(ev.ev_code), 0);
        chk("rst_key_count", 32'(key_count), 0);
        chk("rst_cur_key", 32'(cur_key), 0);
        chk("rst_flags", 32'({overflow, frame_err}), 0);
        SW = 1'b1;
        tick(2);

        for (int i = 0; i < 21; i++) begin
            frame_m(tbl[i].code, tbl[i].bad);
            chk("tbl_cur_key", 32'(cur_key), 32'(tbl[i].cur));
            chk("tbl_key_count", 32'(key_count), tbl[i].cnt);
            chk("tbl_frame_err", 32'(frame_err), 32'(tbl[i].ferr));
            check_all();
            drain();
        end

        // fill, then a write coinciding with a pop, then a dropped write
        frame_m(8'h15, 0);
        frame_m(8'h24, 0);
        frame_m(8'h2D, 0);
        frame_m(8'h2C, 0);
        chk("full_count", 32'(ev.fifo_count), 4);
        chk("full_head", {ev.ev_ext, ev.ev_break, ev.ev_code}, q[0]);
        send_bits(mk_frame(8'h35, 0), 11, 1'b1);
        tick(6);
        void'(q.pop_front());
        model_byte(8'h35, 0);
        chk("simul_count", 32'(ev.fifo_count), 4);
        chk("simul_overflow", 32'(overflow), 0);
        check_all();
        frame_m(8'h3C, 0);
        chk("ovf_count", 32'(ev.fifo_count), 4);
        chk("ovf_flag", 32'(overflow), 1);
        check_all();
        ev.rd_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("burst_head", {ev.ev_ext, ev.ev_break, ev.ev_code}, q[0]);
            tick(1);
            void'(q.pop_front());
        end
        ev.rd_en = 1'b0;
        chk("burst_empty", 32'(ev.ev_valid), 0);
        check_all();

        // abandoned partial frame must not corrupt the next one
        send_bits(mk_frame(8'h5A, 0), 5, 1'b0);
        tick(150);
        frame_m(8'h1C, 0);
        check_all();
        drain();

        for (int i = 0; i < 40; i++) begin
            c = pool[$urandom_range(0, 9)];
            if (c == 8'h00) c = 8'($urandom_range(1, 8'hDF));
            frame_m(c, $urandom_range(0, 9) == 0);
            check_all();
            if ($urandom_range(0, 2) == 0) pop_chk();
        end
        drain();

        frame_m(8'h1C, 0);
        send_bits(mk_frame(8'h33, 0), 4, 1'b0);
        SW = 1'b0;
        tick(1);
        chk("midrst_ev_valid", 32'(ev.ev_valid), 0);
        chk("midrst_fifo_count", 32'(ev.fifo_count), 0);
        chk("midrst_ev_code", 32'(ev.ev_code), 0);
        chk("midrst_key_count", 32'(key_count), 0);
        chk("midrst_cur_key", 32'(cur_key), 0);
        chk("midrst_flags", 32'({overflow, frame_err}), 0);
        PS2_DAT = 1'b1;
        tick(2);
        SW = 1'b1;
        model_reset();
        tick(2);
        check_all();

        frame_m(8'h1C, 0);
        frame_m(8'h32, 0);
        frame_m(8'h21, 0);
        frame_m(8'h23, 0);
        chk("wrap_w2", 32'(kc2), 0);
        chk("wrap_w8", 32'(key_count), 4);
        check_all();
        drain();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/ps2_key_events.md
# ps2_key_events

Parametrised PS/2 keyboard receiver that turns the raw PS2_CLK/PS2_DAT serial stream into decoded key events. It handles E0/F0 prefixes, suppresses typematic repeats and buffers events in a FIFO with a pop handshake. It keeps a distinct-press counter and a held-key register for display. It sits between the PS/2 pins and the board top, where its counter and held-key outputs drive the seven-segment decoders.

## Interface
- FIFO_DEPTH, 8: event FIFO depth; power of two, ≥2.
- CNT_W, 8: width of the key-press counter.
- TIMEOUT_CYC, 50000: CLOCK cycles with no PS2_CLK falling edge before a partial frame is abandoned.
- CLOCK  in  1  system clock; all logic on rising edge.
- SW  in  1  synchronous active-low reset; 0 = reset.
- PS2_CLK  in  1  keyboard clock; asynchronous to CLOCK.
- PS2_DAT  in  1  keyboard data; asynchronous to CLOCK.
- rd_en  in  1  pop the head event when ev_valid=1.
- ev_valid  out  1  FIFO non-empty; head event is presented on ev_*.
- ev_code  out  8  head event scan code, with prefixes stripped.
- ev_ext  out  1  head event had an E0 prefix.
- ev_break  out  1  head event is a release (F0 seen).
- fifo_count  out  $clog2(FIFO_DEPTH)+1  number of stored events.
- overflow  out  1  sticky: an event was dropped because the FIFO was full.
- frame_err  out  1  sticky: a start, parity or stop error was seen.
- key_count  out  CNT_W  number of distinct key presses.
- cur_key  out  8  code of the currently held key; 0x00 when no key is held.

## Operation
- **Input sampling.** PS2_CLK and PS2_DAT each pass through a 2-FF synchroniser. A falling edge is detected on the synchronised clock, and PS2_DAT is sampled on that edge.
- **Frame format.** A frame is 11 bits: start=0, 8 data bits LSB first, odd parity, stop=1. A 4-bit bit counter tracks position.
- **Frame validation.** After the 11th bit the byte is checked.
  - If start=0, odd parity holds and stop=1, the byte is passed to the prefix FSM.
  - Otherwise the byte is discarded, frame_err is set and the prefix FSM returns to IDLE.
- **Timeout.** If the bit counter is non-zero and TIMEOUT_CYC cycles elapse with no falling edge, the bit counter clears and the partial byte is discarded. frame_err is not set.
- **Prefix FSM.** States are IDLE, EXT, BRK and EXT_BRK.
  - IDLE: 0xE0 → EXT; 0xF0 → BRK; any other byte → emit event (ext=0, brk=0).
  - EXT: 0xF0 → EXT_BRK; 0xE0 → stay in EXT; any other byte → emit (1,0), then IDLE.
  - BRK: any byte other than E0/F0 → emit (0,1), then IDLE. E0 or F0 → IDLE, no emit.
  - EXT_BRK: any byte other than E0/F0 → emit (1,1), then IDLE. E0 or F0 → IDLE, no emit.
- **Held key.** The held key is stored as {held_valid, held_ext, held_code}.
  - Make event: if the key is not held, key_count increments and the held key is set to {1,ext,code}. If it is already held (typematic repeat), neither key_count nor the held key changes.
  - Break event matching {ext,code}: held_valid clears.
  - Break event not matching: no change to the held key.
  - cur_key = held_valid ? held_code : 0x00.
- **Counter wrap.** key_count wraps from 2^CNT_W−1 to 0 with no flag.
- **FIFO recording.** Every emitted event, including repeats and breaks, is written as {ext,brk,code}.
- **FIFO behaviour.** The FIFO is first-word-fall-through.
  - rd_en when empty is ignored.
  - Write when full with no simultaneous read: the event is dropped and overflow is set. key_count and the held key still update.
  - Write and read in the same cycle when full: both are accepted, count is unchanged and overflow is not set.
- **Sticky flags.** overflow and frame_err clear only on reset.
- **Reset (SW=0, sampled on CLOCK).** The following are cleared, and reset mid-frame abandons the frame:
  - all outputs to 0;
  - bit counter, FSM (to IDLE), FIFO pointers, held key, timeout counter;
  - synchroniser flops, which are set to 1 (idle bus).

## Timing
- **Edge detection.** A falling edge on the PS2_CLK pin is detected 3 CLOCK cycles later (2 sync stages plus 1 edge register).
- **Stop to FSM.** The stop-bit sample feeds the FSM on the next cycle.
- **FSM to FIFO.** An emitted event is written to the FIFO one cycle after the FSM update.
- **Event visibility.** ev_valid and ev_* are registered outputs and rise 1 cycle after the write. Counting from the stop-bit falling-edge detection, the event is visible 3 cycles later.
- **Counter and held key.** key_count and cur_key update in the same cycle as the FIFO write.
- **Pop.** A pop with rd_en=1 at edge N presents the next entry, or drops ev_valid, after edge N.
- **Throughput.** PS/2 bit periods (≥60 µs) exceed the pipeline latency, so there is no back-pressure toward the keyboard.

## Test plan
- **Simple press/release.** Reset, then send 0x1C, F0 1C.
  - FIFO holds {0,0,1C} and {0,1,1C}.
  - key_count=1; cur_key=1C after the make and 00 after the break.
- **Extended key.** Send E0 75, E0 F0 75.
  - Events {1,0,75} and {1,1,75}.
  - key_count increments once.
  - cur_key=75, then 00.
- **Typematic repeat.** Send 1C ×5, then F0 1C.
  - Six FIFO events.
  - key_count=1.
  - A later 1C makes key_count=2.
- **Frame error.** Send 0x1C with bad parity, then a valid 0x32.
  - frame_err=1.
  - Only {0,0,32} is stored.
  - Send F0, then a bad frame, then 1C: the FSM has returned to IDLE, so a make {0,0,1C} is emitted.
- **FIFO limits.** With FIFO_DEPTH=4, send 5 makes of distinct codes with rd_en=0.
  - fifo_count=4, overflow=1, key_count=5.
  - Pop all four in consecutive cycles: ev_valid drops after the 4th.
  - Full plus simultaneous write and read: count stays 4, overflow is not newly set.
- **Timeout, reset and wrap.**
  - Send 5 bits and stall >TIMEOUT_CYC, then send 0x1C: decoded correctly.
  - Assert SW=0 mid-frame: all outputs 0 the next cycle.
  - With CNT_W=2, 4 distinct presses: key_count wraps to 0.
